kv_fpu_fmv_pipe: RTL and testbench

`kv_fpu_fmv_pipe` is the parametrised, pipelined move, sign-injection and classify unit for the FPU F1 issue slot. It performs FMV.X/FMV.F, FSGNJ/FSGNJN/FSGNJX and FCLASS for 64-, 32- and 16-bit SEW, where 16-bit SEW means FP16, or BF16 when `fp_mode`=1. Operands are NaN-box checked against `FLEN`. The result passes through `LAT` register stages with a valid/ready handshake, full back-pressure, a per-op tag and a synchronous flush.

---
 rtl/kv_fpu_fmv_pipe.sv | 197 +++++++++++++++++++
 tb/tb_kv_fpu_fmv_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kv_fpu_fmv_pipe.sv
// FPU F1 move / sign-injection / classify unit with an LAT-deep valid/ready pipeline.
// The result is formed combinationally at entry; later stages only carry it forward.
module kv_fpu_fmv_pipe #(
    parameter int unsigned FLEN = 64,
    parameter int unsigned LAT  = 1,
    parameter int unsigned TAGW = 5
) (
    input  logic            core_clk,
    input  logic            core_reset,
    input  logic            fp_mode,
    input  logic            f1_valid,
    output logic            f1_ready,
    input  logic [5:0]      f1_ex_ctrl,
    input  logic [2:0]      f1_sew,
    input  logic [63:0]     f1_op1_data,
    input  logic [63:0]     f1_op2_data,
    input  logic [TAGW-1:0] f1_tag,
    input  logic            flush,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [63:0]     o_wdata,
    output logic [TAGW-1:0] o_tag,
    output logic            fmv_standby_ready
);

    localparam logic [4:0] FPU_FSGNJ_5B  = 5'h08;
    localparam logic [4:0] FPU_FSGNJN_5B = 5'h09;
    localparam logic [4:0] FPU_FSGNJX_5B = 5'h0a;
    localparam logic [4:0] FPU_FMVF2I_5B = 5'h0c;
    localparam logic [4:0] FPU_FMVI2F_5B = 5'h0d;
    localparam logic [4:0] FPU_FCLASS_5B = 5'h0e;

    function automatic logic box32(input logic [63:0] v);
        return (FLEN == 32) ? 1'b1 : &v[63:32];
    endfunction

    function automatic logic box16(input logic [63:0] v);
        return &v[FLEN-1:16];
    endfunction

    function automatic logic inj_sign(input logic [4:0] op, input logic s1, input logic s2);
        case (op)
            FPU_FSGNJN_5B: return ~s2;
            FPU_FSGNJX_5B: return s1 ^ s2;
            default:       return s2;
        endcase
    endfunction

    // RISC-V class mask from sign, exponent all-ones/all-zeros, mantissa zero, mantissa msb
    function automatic logic [9:0] fclass(input logic s, input logic e1, input logic e0,
                                          input logic mz, input logic mmsb);
        logic [9:0] c;
        c    = '0;
        c[0] = s & e1 & mz;
        c[1] = s & ~e1 & ~e0;
        c[2] = s & e0 & ~mz;
        c[3] = s & e0 & mz;
        c[4] = ~s & e0 & mz;
        c[5] = ~s & e0 & ~mz;
        c[6] = ~s & ~e1 & ~e0;
        c[7] = ~s & e1 & mz;
        c[8] = e1 & ~mz & ~mmsb;
        c[9] = e1 & ~mz & mmsb;
        return c;
    endfunction

    logic [4:0]  op_c;
    logic        sew64_c, sew32_c, sew16_c;
    logic [31:0] a32_c;
    logic [15:0] a16_c;
    logic [9:0]  cls_c;
    logic [63:0] res_c;
    logic        unused_c;

    assign op_c     = f1_ex_ctrl[4:0];
    assign sew64_c  = (f1_sew == 3'b100) && (FLEN == 64);
    assign sew32_c  = (f1_sew == 3'b010);
    assign sew16_c  = (f1_sew == 3'b001);
    assign unused_c = ^{f1_ex_ctrl[5], f1_op2_data};

    // Entry-stage result
    always_comb begin
        res_c = '0;
        cls_c = '0;
        a32_c = box32(f1_op1_data) ? f1_op1_data[31:0] : 32'h7fc0_0000;
        a16_c = box16(f1_op1_data) ? f1_op1_data[15:0] : (fp_mode ? 16'h7fc0 : 16'h7e00);
        case (op_c)
            FPU_FMVI2F_5B, FPU_FMVF2I_5B: begin
                if (sew64_c)
                    res_c = f1_op1_data;
                else if (sew32_c)
                    res_c = {(op_c == FPU_FMVI2F_5B) ? 32'hffff_ffff : {32{f1_op1_data[31]}},
                             f1_op1_data[31:0]};
                else if (sew16_c)
                    res_c = {(op_c == FPU_FMVI2F_5B) ? 48'hffff_ffff_ffff : {48{f1_op1_data[15]}},
                             f1_op1_data[15:0]};
            end
            FPU_FSGNJ_5B, FPU_FSGNJN_5B, FPU_FSGNJX_5B: begin
                if (sew64_c)
                    res_c = {inj_sign(op_c, f1_op1_data[63], f1_op2_data[63]), f1_op1_data[62:0]};
                else if (sew32_c)
                    res_c = {32'hffff_ffff,
                             inj_sign(op_c, a32_c[31], box32(f1_op2_data) & f1_op2_data[31]),
                             a32_c[30:0]};
                else if (sew16_c)
                    res_c = {48'hffff_ffff_ffff,
                             inj_sign(op_c, a16_c[15], box16(f1_op2_data) & f1_op2_data[15]),
                             a16_c[14:0]};
            end
            FPU_FCLASS_5B: begin
                if (sew64_c)
                    cls_c = fclass(f1_op1_data[63], &f1_op1_data[62:52], ~|f1_op1_data[62:52],
                                   ~|f1_op1_data[51:0], f1_op1_data[51]);
                else if (sew32_c)
                    cls_c = box32(f1_op1_data)
                          ? fclass(f1_op1_data[31], &f1_op1_data[30:23], ~|f1_op1_data[30:23],
                                   ~|f1_op1_data[22:0], f1_op1_data[22])
                          : 10'h200;
                else if (sew16_c && !box16(f1_op1_data))
                    cls_c = 10'h200;
                else if (sew16_c && fp_mode)
                    cls_c = fclass(f1_op1_data[15], &f1_op1_data[14:7], ~|f1_op1_data[14:7],
                                   ~|f1_op1_data[6:0], f1_op1_data[6]);
                else if (sew16_c)
                    cls_c = fclass(f1_op1_data[15], &f1_op1_data[14:10], ~|f1_op1_data[14:10],
                                   ~|f1_op1_data[9:0], f1_op1_data[9]);
                res_c = 64'(cls_c);
            end
            default: res_c = '0;
        endcase
    end

    logic [LAT-1:0]  vld_q, vld_d, adv_c;
    logic [63:0]     data_q [LAT];
    logic [63:0]     data_d [LAT];
    logic [TAGW-1:0] tag_q  [LAT];
    logic [TAGW-1:0] tag_d  [LAT];
    logic            full_c;

    // A stage advances unless it and every stage below it are full while the output stalls
    always_comb begin
        adv_c  = '0;
        full_c = 1'b1;
        for (int unsigned i = 0; i < LAT; i++) begin
            full_c = 1'b1;
            for (int unsigned j = i; j < LAT; j++) full_c = full_c & vld_q[j];
            adv_c[i] = ~full_c | o_ready;
        end
    end

    assign f1_ready          = adv_c[0] & ~flush;
    assign o_valid           = vld_q[LAT-1];
    assign o_wdata           = data_q[LAT-1];
    assign o_tag             = tag_q[LAT-1];
    assign fmv_standby_ready = ~f1_valid & ~|vld_q;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        tag_d  = tag_q;
        if (flush) begin
            vld_d = '0;
        end else begin
            if (adv_c[0]) begin
                vld_d[0] = f1_valid;
                if (f1_valid) begin
                    data_d[0] = res_c;
                    tag_d[0]  = f1_tag;
                end
            end
            for (int unsigned i = 1; i < LAT; i++) begin
                if (adv_c[i]) begin
                    vld_d[i] = vld_q[i-1];
                    if (vld_q[i-1]) begin
                        data_d[i] = data_q[i-1];
                        tag_d[i]  = tag_q[i-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            tag_q  <= tag_d;
        end
    end

endmodule

// File: tb/tb_kv_fpu_fmv_pipe.sv
// Scoreboard bench: u_a is FLEN=64/LAT=3, u_b is FLEN=32/LAT=1; they share all inputs but f1_valid.
module tb_kv_fpu_fmv_pipe;

    localparam int unsigned LAT_A = 3;
    localparam logic [4:0] OP_SGNJ  = 5'h08;
    localparam logic [4:0] OP_SGNJN = 5'h09;
    localparam logic [4:0] OP_SGNJX = 5'h0a;
    localparam logic [4:0] OP_F2I   = 5'h0c;
    localparam logic [4:0] OP_I2F   = 5'h0d;
    localparam logic [4:0] OP_CLASS = 5'h0e;
    localparam logic [2:0] S64 = 3'b100, S32 = 3'b010, S16 = 3'b001;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  tag;
    } exp_t;

    logic        clk, core_reset, fp_mode, valid_a, valid_b, flush, o_ready;
    logic [5:0]  ctrl;
    logic [2:0]  sew;
    logic [63:0] op1, op2;
    logic [4:0]  tag;
    logic        rdy_a, rdy_b, o_valid_a, o_valid_b, sb_a, sb_b;
    logic [63:0] o_wdata_a, o_wdata_b;
    logic [4:0]  o_tag_a, o_tag_b;

    exp_t        qa[$];
    exp_t        qb[$];
    int          n_checks, n_err, occ_a;
    logic [4:0]  tag_ctr;
    logic        stall_prev;
    logic [63:0] prev_data;
    logic [4:0]  prev_tag;

    kv_fpu_fmv_pipe #(.FLEN(64), .LAT(LAT_A), .TAGW(5)) u_a (
        .core_clk(clk), .core_reset(core_reset), .fp_mode(fp_mode),
        .f1_valid(valid_a), .f1_ready(rdy_a), .f1_ex_ctrl(ctrl), .f1_sew(sew),
        .f1_op1_data(op1), .f1_op2_data(op2), .f1_tag(tag), .flush(flush),
        .o_valid(o_valid_a), .o_ready(o_ready), .o_wdata(o_wdata_a), .o_tag(o_tag_a),
        .fmv_standby_ready(sb_a)
    );

    kv_fpu_fmv_pipe #(.FLEN(32), .LAT(1), .TAGW(5)) u_b (
        .core_clk(clk), .core_reset(core_reset), .fp_mode(fp_mode),
        .f1_valid(valid_b), .f1_ready(rdy_b), .f1_ex_ctrl(ctrl), .f1_sew(sew),
        .f1_op1_data(op1), .f1_op2_data(op2), .f1_tag(tag), .flush(flush),
        .o_valid(o_valid_b), .o_ready(o_ready), .o_wdata(o_wdata_b), .o_tag(o_tag_b),
        .fmv_standby_ready(sb_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Present one op to u_a or u_b and hold it until accepted; expectation queued on accept
    task automatic issue(input bit to_b, input logic [4:0] opc, input logic [2:0] s,
                         input logic [63:0] a, input logic [63:0] b, input logic fpm,
                         input logic [63:0] expv);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        ctrl    = {1'b0, opc};
        sew     = s;
        op1     = a;
        op2     = b;
        fp_mode = fpm;
        tag     = tag_ctr;
        valid_a = !to_b;
        valid_b = to_b;
        for (int k = 0; k < 100 && !ok; k++) begin
            #1;
            if ((to_b ? rdy_b : rdy_a) === 1'b1) begin
                if (to_b) qb.push_back('{data: expv, tag: tag_ctr});
                else      qa.push_back('{data: expv, tag: tag_ctr});
                ok = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout: actual no accept required accept for tag %0d", tag_ctr);
        end
        tag_ctr = tag_ctr + 5'd1;
    endtask

    task automatic idle();
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && (qa.size() != 0 || qb.size() != 0); c++) @(negedge clk);
        chk("drain_a", 64'(qa.size()), 64'd0);
        chk("drain_b", 64'(qb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: scoreboard pops, occupancy model for f1_ready, stall stability
    initial begin
        exp_t e;
        logic acc, xfer;
        forever begin
            @(negedge clk);
            #2;
            acc  = valid_a & rdy_a;
            xfer = o_valid_a & o_ready;
            if (!core_reset && !flush) begin
                chk("ready_a", 64'(rdy_a), 64'((occ_a != int'(LAT_A)) || o_ready));
                if (stall_prev) begin
                    chk("stall_data", o_wdata_a, prev_data);
                    chk("stall_tag", 64'(o_tag_a), 64'(prev_tag));
                end
                if (o_valid_a && o_ready) begin
                    if (qa.size() == 0) begin
                        chk("unexpected_a", 64'(o_tag_a), 64'h1_0000);
                    end else begin
                        e = qa.pop_front();
                        chk("data_a", o_wdata_a, e.data);
                        chk("tag_a", 64'(o_tag_a), 64'(e.tag));
                    end
                end
                if (o_valid_b && o_ready) begin
                    if (qb.size() == 0) begin
                        chk("unexpected_b", 64'(o_tag_b), 64'h1_0000);
                    end else begin
                        e = qb.pop_front();
                        chk("data_b", o_wdata_b, e.data);
                        chk("tag_b", 64'(o_tag_b), 64'(e.tag));
                    end
                end
                occ_a      = occ_a + int'(acc) - int'(xfer);
                stall_prev = o_valid_a & ~o_ready;
                prev_data  = o_wdata_a;
                prev_tag   = o_tag_a;
            end else begin
                occ_a      = 0;
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        bit [3:0]    pat;
        core_reset = 1'b1; fp_mode = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        flush = 1'b0; o_ready = 1'b0; ctrl = '0; sew = '0; op1 = '0; op2 = '0; tag = '0;
        n_checks = 0; n_err = 0; occ_a = 0; tag_ctr = '0; stall_prev = 1'b0;
        prev_data = '0; prev_tag = '0;
        pat = 4'b1001;
        repeat (3) @(negedge clk);
        core_reset = 1'b0;
        #1;
        chk("rst_valid_a", 64'(o_valid_a), 64'd0);
        chk("rst_wdata_a", o_wdata_a, 64'd0);
        chk("rst_tag_a", 64'(o_tag_a), 64'd0);
        chk("rst_standby_a", 64'(sb_a), 64'd1);
        chk("rst_valid_b", 64'(o_valid_b), 64'd0);
        chk("rst_standby_b", 64'(sb_b), 64'd1);

        // Latency on u_a: accepted at edge N, visible after N+2
        o_ready = 1'b1;
        issue(0, OP_SGNJN, S32, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_00000000, 0, 64'hFFFFFFFF_BF800000);
        @(negedge clk); valid_a = 1'b0; #1;
        chk("lat_n", 64'(o_valid_a), 64'd0);
        @(negedge clk); #1;
        chk("lat_n1", 64'(o_valid_a), 64'd0);
        @(negedge clk); #1;
        chk("lat_n2", 64'(o_valid_a), 64'd1);
        drain();

        // Directed vectors on FLEN=64, back to back
        issue(0, OP_SGNJN, S32, 64'h00000000_3F800000, 64'hFFFFFFFF_00000000, 0, 64'hFFFFFFFF_FFC00000);
        issue(0, OP_SGNJX, S16, 64'h0, 64'h0, 0, 64'hFFFFFFFF_FFFF7E00);
        issue(0, OP_SGNJX, S16, 64'h0, 64'h0, 1, 64'hFFFFFFFF_FFFF7FC0);
        issue(0, OP_F2I,   S16, 64'h00000000_00008001, 64'h0, 0, 64'hFFFFFFFF_FFFF8001);
        issue(0, OP_I2F,   S32, 64'h12345678_00001234, 64'h0, 0, 64'hFFFFFFFF_00001234);
        issue(0, OP_F2I,   S32, 64'h12345678_00001234, 64'h0, 0, 64'h00000000_00001234);
        issue(0, OP_F2I,   S64, 64'h12345678_9ABCDEF0, 64'h0, 0, 64'h12345678_9ABCDEF0);
        issue(0, OP_SGNJ,  S64, 64'h3FF00000_00000000, 64'h80000000_00000000, 0, 64'hBFF00000_00000000);
        issue(0, OP_SGNJX, S64, 64'hBFF00000_00000000, 64'h80000000_00000000, 0, 64'h3FF00000_00000000);
        issue(0, OP_SGNJ,  S16, 64'hFFFFFFFF_FFFF3C00, 64'hFFFFFFFF_FFFF8000, 0, 64'hFFFFFFFF_FFFFBC00);
        issue(0, OP_SGNJ,  S16, 64'hFFFFFFFF_FFFF3C00, 64'h00000000_00008000, 0, 64'hFFFFFFFF_FFFF3C00);
        issue(0, OP_CLASS, S32, 64'hFFFFFFFF_FF800000, 64'h0, 0, 64'h001);
        issue(0, OP_CLASS, S64, 64'h0, 64'h0, 0, 64'h010);
        issue(0, OP_CLASS, S16, 64'hFFFFFFFF_FFFFFF81, 64'h0, 1, 64'h100);
        issue(0, OP_CLASS, S32, 64'h00000000_3F800000, 64'h0, 0, 64'h200);
        issue(0, OP_CLASS, S64, 64'hBFF00000_00000000, 64'h0, 0, 64'h002);
        issue(0, OP_CLASS, S32, 64'hFFFFFFFF_7F800000, 64'h0, 0, 64'h080);
        issue(0, OP_CLASS, S32, 64'hFFFFFFFF_80000000, 64'h0, 0, 64'h008);
        issue(0, OP_CLASS, S16, 64'hFFFFFFFF_FFFFFC00, 64'h0, 0, 64'h001);
        issue(0, OP_CLASS, S16, 64'hFFFFFFFF_FFFF0001, 64'h0, 0, 64'h020);
        issue(0, OP_CLASS, S16, 64'h00000000_FFFF3C00, 64'h0, 0, 64'h200);
        issue(0, 5'h1f,    S32, 64'hFFFFFFFF_3F800000, 64'h0, 0, 64'h0);
        issue(0, OP_SGNJ,  3'b011, 64'hFFFFFFFF_3F800000, 64'h0, 0, 64'h0);
        idle();
        drain();

        // FLEN=32 instance
        issue(1, OP_SGNJ,  S64, 64'h3FF00000_00000000, 64'h80000000_00000000, 0, 64'h0);
        issue(1, OP_CLASS, S64, 64'h0, 64'h0, 0, 64'h0);
        issue(1, OP_SGNJ,  S32, 64'h00000000_3F800000, 64'h00000000_80000000, 0, 64'hFFFFFFFF_BF800000);
        issue(1, OP_CLASS, S32, 64'h00000000_3F800000, 64'h0, 0, 64'h040);
        issue(1, OP_CLASS, S16, 64'h00000000_FFFF3C00, 64'h0, 0, 64'h040);
        issue(1, OP_CLASS, S16, 64'h00000000_00003C00, 64'h0, 0, 64'h200);
        idle();
        drain();

        // Back-pressure: 8 ops, tags 0..7, o_ready pattern 1-0-0-1
        tag_ctr = '0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    v = 64'hA5A5_0000_0000_0000 | (64'(i) << 8) | 64'(i);
                    issue(0, OP_F2I, S64, v, 64'h0, 0, v);
                end
                idle();
            end
            begin
                for (int c = 0; c < 24; c++) begin
                    @(negedge clk);
                    o_ready = pat[c % 4];
                end
            end
        join
        o_ready = 1'b1;
        drain();

        // Flush with 3 ops in flight plus a presented op
        @(negedge clk); o_ready = 1'b0;
        issue(0, OP_F2I, S64, 64'h1, 64'h0, 0, 64'h1);
        issue(0, OP_F2I, S64, 64'h2, 64'h0, 0, 64'h2);
        issue(0, OP_F2I, S64, 64'h3, 64'h0, 0, 64'h3);
        @(negedge clk);
        op1 = 64'h4; tag = 5'd30; valid_a = 1'b1; flush = 1'b1;
        #1;
        chk("flush_ready", 64'(rdy_a), 64'd0);
        @(posedge clk);
        qa.delete();
        @(negedge clk);
        flush = 1'b0; valid_a = 1'b0; o_ready = 1'b1;
        #1;
        chk("flush_valid", 64'(o_valid_a), 64'd0);
        chk("flush_standby", 64'(sb_a), 64'd1);
        repeat (5) @(negedge clk);

        // Reset mid-stream
        issue(0, OP_F2I, S64, 64'h5, 64'h0, 0, 64'h5);
        issue(0, OP_F2I, S64, 64'h6, 64'h0, 0, 64'h6);
        @(negedge clk);
        valid_a = 1'b0; core_reset = 1'b1;
        @(posedge clk);
        qa.delete();
        qb.delete();
        @(negedge clk);
        core_reset = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(o_valid_a), 64'd0);
        chk("rst_mid_standby", 64'(sb_a), 64'd1);
        repeat (5) @(negedge clk);
        chk("final_qa", 64'(qa.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
